// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the 65C02 bus: a CPU-writable byte FIFO
// feeding a serial engine, with registered (one-cycle) reads of STATUS and LEVEL.
module uart_tx_port #(
  parameter int BAUD_DIV = 27,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] reg_addr,
  input  logic       write_enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [BW-1:0]      BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LEVEL  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  state_e             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [7:0]         data_out_q, data_out_d;

  logic fifo_full, fifo_empty, baud_done;
  logic push_req, push_ok, pop_en, status_wr;

  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    baud_done  = (baud_q == '0);
    push_req   = sel && write_enable && (reg_addr == REG_DATA);
    status_wr  = sel && write_enable && (reg_addr == REG_STATUS);
  end

  // Serial engine. tx_d is computed from the state being entered so that tx is a
  // plain flop output and changes exactly on state/bit boundaries.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop_en  = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = S_START;
          baud_d  = BAUD_LAST;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d   = S_DATA;
          baud_d    = BAUD_LAST;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            pop_en  = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    push_ok  = push_req && (!fifo_full || pop_en);
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_en  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (status_wr) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  assign busy = (state_q != S_IDLE) || !fifo_empty;

  // Read path samples the pre-update register values.
  always_comb begin
    data_out_d = 8'h00;
    if (sel) begin
      unique case (reg_addr)
        REG_STATUS: data_out_d = {4'b0000, overflow_q, busy, fifo_full, fifo_empty};
        REG_LEVEL:  data_out_d = 8'(count_q);
        default:    data_out_d = 8'h00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      data_out_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      data_out_q <= data_out_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers define validity,
  // and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= data_in;
  end

  assign tx       = tx_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port (BAUD_DIV=4, FIFO_AW=2): directed bus steps,
// a serial-line monitor and a byte scoreboard.
module tb_uart_tx_port;

  localparam int BAUD  = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic [1:0] reg_addr;
  logic       write_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       tx;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_port #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .reg_addr     (reg_addr),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; write_enable = 1'b1; reg_addr = a; data_in = d;
    tick();
    sel = 1'b0; write_enable = 1'b0; reg_addr = 2'd0; data_in = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_q.push_back(d);
    write_reg(2'd0, d);
  endtask

  task automatic read_reg(input logic [1:0] a, input logic [7:0] expv, input string tag);
    sel = 1'b1; reg_addr = a;
    tick();
    sel = 1'b0; reg_addr = 2'd0;
    check(tag, data_out, expv);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_starts(input int n, input string tag);
    int i = 0;
    while (starts.size() < n && i < 2000) begin
      tick();
      i++;
    end
    check(tag, starts.size() >= n, 1);
  endtask

  task automatic mon_wait(input int n, inout logic ab);
    repeat (n) begin
      @(posedge clk);
      if (reset) ab = 1'b1;
    end
    #1;
  endtask

  // Line monitor: samples each bit mid-cell and checks it against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    logic       aborted;
    forever begin
      @(negedge tx);
      #1;
      starts.push_back(cyc);
      aborted = 1'b0;
      check("frame_expected", exp_q.size() != 0, 1);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      got  = 8'h00;
      mon_wait(BAUD / 2, aborted);
      if (!aborted) check("start_bit", tx, 0);
      for (int i = 0; i < 8; i++) begin
        mon_wait(BAUD, aborted);
        got[i] = tx;
      end
      mon_wait(BAUD, aborted);
      if (!aborted) begin
        check("stop_bit", tx, 1);
        check("frame_data", got, want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] pat;
    logic       exp_bit;
    int n0, n1, s;

    reset = 1'b1; sel = 1'b0; write_enable = 1'b0; reg_addr = 2'd0; data_in = 8'h00;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    read_reg(2'd1, 8'h01, "status_after_reset");
    check("idle_tx", tx, 1);
    read_reg(2'd2, 8'h00, "level_after_reset");

    // Single frame 0xA5, checked cycle by cycle from the write.
    pat = 8'hA5;
    push_byte(pat);
    check("a5_tx_before_start", tx, 1);
    check("a5_busy_early", busy, 1);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k < BAUD)          exp_bit = 1'b0;
      else if (k < 9 * BAUD) exp_bit = pat[(k - BAUD) / BAUD];
      else                   exp_bit = 1'b1;
      check("a5_tx_cycle", tx, exp_bit);
      if (k == FRAME - 1) check("a5_busy_last", busy, 1);
    end
    tick();
    check("a5_busy_fall", busy, 0);
    check("a5_tx_idle", tx, 1);

    // Three back-to-back writes: contiguous frames, level draining.
    n0 = starts.size();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    read_reg(2'd2, 8'h02, "b2b_level_2");
    wait_starts(n0 + 1, "b2b_first_start");
    s = starts[n0];
    wait_until(s + FRAME + 5);
    read_reg(2'd2, 8'h01, "b2b_level_1");
    wait_until(s + 2 * FRAME + 5);
    read_reg(2'd2, 8'h00, "b2b_level_0");
    wait_starts(n0 + 3, "b2b_all_start");
    check("b2b_gap_1", starts[n0 + 1] - starts[n0], FRAME);
    check("b2b_gap_2", starts[n0 + 2] - starts[n0 + 1], FRAME);
    wait_until(starts[n0 + 2] + FRAME + 1);
    check("b2b_busy_fall", busy, 0);

    // Overflow with a depth-4 FIFO while the first frame is in flight.
    n0 = starts.size();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    push_byte(8'h05);
    write_reg(2'd0, 8'hEE);
    read_reg(2'd1, 8'h0E, "ovf_status_set");
    read_reg(2'd2, 8'h04, "ovf_level_full");
    write_reg(2'd1, 8'h00);
    read_reg(2'd1, 8'h06, "ovf_status_cleared");

    // Write into a full FIFO on the exact cycle the FSM pops.
    wait_starts(n0 + 1, "ovf_first_start");
    s = starts[n0];
    wait_until(s + FRAME - 1);
    push_byte(8'h77);
    read_reg(2'd1, 8'h06, "pop_push_status");
    read_reg(2'd2, 8'h04, "pop_push_level");
    wait_starts(n0 + 6, "ovf_drain_start");
    wait_until(starts[n0 + 5] + FRAME + 1);
    check("drain_busy", busy, 0);
    read_reg(2'd1, 8'h01, "drain_status");
    check("drain_scoreboard_empty", exp_q.size(), 0);

    // Reset in the middle of bit 0 (a zero bit) of 0x3C with more bytes queued.
    n0 = starts.size();
    push_byte(8'h3C);
    push_byte(8'h5A);
    push_byte(8'h99);
    wait_starts(n0 + 1, "rst_frame_start");
    s = starts[n0];
    wait_until(s + BAUD + 1);
    check("pre_reset_tx", tx, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_tx_high", tx, 1);
    check("reset_data_out", data_out, 8'h00);
    exp_q.delete();
    n1 = starts.size();
    read_reg(2'd2, 8'h00, "reset_level");
    read_reg(2'd1, 8'h01, "reset_status");
    repeat (100) tick();
    check("no_frames_after_reset", starts.size(), n1);
    check("tx_idle_after_reset", tx, 1);
    check("busy_after_reset", busy, 0);
    reg_addr = 2'd1;
    tick();
    check("unselected_read", data_out, 8'h00);
    reg_addr = 2'd0;
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
